mult_bcd_seq: RTL and testbench
===============================

MULT_BCD_SEQ -- requirements
Module: mult_bcd_seq

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width fixed at 8 bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to multiply a*b; level sampled on each rising edge.
REQ-005 a  input  4  unsigned operand A, captured when start is accepted.
REQ-006 b  input  4  unsigned operand B, captured when start is accepted.
REQ-007 busy  output  1  high while a multiply/convert operation is in progress.
REQ-008 done  output  1  one-cycle pulse when new results are valid.
REQ-009 product  output  8  registered binary product of the last completed operation.
REQ-010 bcd2  output  4  hundreds digit of product (0-2).
REQ-011 bcd1  output  4  tens digit of product (0-9).
REQ-012 bcd0  output  4  ones digit of product (0-9); bcd2..bcd0 feed the multi-digit 7-segment display stage.

Function
REQ-013 FSM states SHALL be IDLE, MULT and CONV; no other state is reachable.
REQ-014 In IDLE, start=1 at an edge SHALL capture a and b, clear the accumulator and step counter, and move to MULT (the accept edge, E0).
REQ-015 MULT SHALL perform one shift-add step per cycle, LSB of B first, for exactly 4 edges (E1-E4), then move to CONV.
REQ-016 Each MULT step: if current B bit = 1, add A shifted by step index to the 8-bit accumulator; no overflow is possible (max 15*15 = 225).
REQ-017 CONV SHALL run double-dabble on the 8-bit product for exactly 8 edges (E5-E12): before each left shift, add 3 to any BCD nibble >= 5.
REQ-018 At E12, product, bcd2, bcd1 and bcd0 SHALL update together, done SHALL be 1 for the following cycle only, and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: done high in the cycle after E12, i.e. 12 cycles after the accept edge, for every operand pair.
REQ-020 busy SHALL be 1 in MULT and CONV and 0 in IDLE; busy falls in the same cycle that done rises.
REQ-021 start while busy=1 SHALL be ignored (not queued); operand changes while busy SHALL NOT affect the result in progress.
REQ-022 start held high continuously SHALL begin a new operation at the first IDLE edge, i.e. the edge during which done=1, giving back-to-back operations every 13 cycles.
REQ-023 Result outputs SHALL hold their previous values for the whole duration of an operation, with no intermediate values visible to the display stage.
REQ-024 Zero operands SHALL follow the same 12-cycle path and yield product=0 with all digits 0.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, product=0, bcd2=bcd1=bcd0=0, and clear the accumulator and counters.
REQ-026 rst SHALL take priority over start on the same edge, and SHALL abort an operation in progress with no done pulse.
REQ-027 After rst is released, the first start SHALL be accepted at the next edge where it is high.

Verification
REQ-028 Reset, then a=2, b=2, start pulse -> done exactly 12 cycles after accept; product=8'd4; bcd2/1/0 = 0/0/4.
REQ-029 a=7, b=2 -> product=14, digits 0/1/4; then a=5, b=2 -> product=10, digits 0/1/0; then a=3, b=3 -> product=9, digits 0/0/9.
REQ-030 a=15, b=15 -> product=225, digits 2/2/5; a=0, b=9 -> product=0, digits 0/0/0, same 12-cycle latency.
REQ-031 Start a=4, b=4; at cycle 3 of busy, pulse start with a=9, b=9 -> single done, product=16, digits 0/1/6; outputs hold the old values until done.
REQ-032 Start a=6, b=7; assert rst at cycle 6 of busy -> no done pulse, all outputs 0 next cycle; a new start with a=6, b=7 then gives product=42, digits 0/4/2.
REQ-033 start held high with a=3, b=5 -> done pulses every 13 cycles; each pulse shows product=15, digits 0/1/5; busy=0 only in the done cycle.

Source files
------------

// File: rtl/mult_bcd_seq.sv
// Sequential 4x4 shift-add multiplier with double-dabble BCD conversion.
// Ports: clk, rst (sync, active-high), start/a/b in; busy, done, product, bcd2..bcd0 out.
module mult_bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    CONV = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  a_q;
  logic [3:0]  b_q;
  logic [7:0]  acc_q;
  logic [2:0]  cnt_q;
  // {hundreds, tens, ones, binary} working register
  logic [19:0] dd_q;

  logic [7:0]  addend;
  logic [7:0]  acc_sum;
  logic [19:0] dd_adj;
  logic [19:0] dd_shift;

  function automatic logic [3:0] adj3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    addend = 8'd0;
    if (b_q[cnt_q[1:0]])
      addend = {4'b0, a_q} << cnt_q[1:0];
    acc_sum = acc_q + addend;
  end

  always_comb begin
    dd_adj          = dd_q;
    dd_adj[19:16]   = adj3(dd_q[19:16]);
    dd_adj[15:12]   = adj3(dd_q[15:12]);
    dd_adj[11:8]    = adj3(dd_q[11:8]);
    dd_shift        = {dd_adj[18:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = MULT;
      MULT: if (cnt_q == 3'd3) state_d = CONV;
      CONV: if (cnt_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      acc_q   <= 8'd0;
      cnt_q   <= 3'd0;
      dd_q    <= 20'd0;
      done    <= 1'b0;
      product <= 8'd0;
      bcd2    <= 4'd0;
      bcd1    <= 4'd0;
      bcd0    <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= 8'd0;
            cnt_q <= 3'd0;
          end
        end
        MULT: begin
          acc_q <= acc_sum;
          if (cnt_q == 3'd3) begin
            cnt_q <= 3'd0;
            dd_q  <= {12'd0, acc_sum};
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        CONV: begin
          dd_q <= dd_shift;
          if (cnt_q == 3'd7) begin
            // all result outputs move together; they hold otherwise
            cnt_q   <= 3'd0;
            done    <= 1'b1;
            product <= acc_q;
            bcd2    <= dd_shift[19:16];
            bcd1    <= dd_shift[15:12];
            bcd0    <= dd_shift[11:8];
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_bcd_seq.sv
// Scoreboard bench for mult_bcd_seq.
// Driver pushes expected results; monitor pops on done.
module tb_mult_bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;

  mult_bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .bcd2    (bcd2),
    .bcd1    (bcd1),
    .bcd0    (bcd0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         de;
    logic [7:0] p;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } exp_t;

  exp_t q[$];
  int   edge_n   = 0;
  int   free_at  = 0;
  int   last_k   = -100;
  int   abort_e  = 1 << 30;
  int   last_rst = -100;
  int   n_chk    = 0;
  int   n_fail   = 0;

  logic [7:0] h_p  = 8'd0;
  logic [3:0] h_d2 = 4'd0;
  logic [3:0] h_d1 = 4'd0;
  logic [3:0] h_d0 = 4'd0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // inputs set here take effect at edge k = edge_n+1
  task automatic step(
    input logic       r,
    input logic       s,
    input logic [3:0] x,
    input logic [3:0] y
  );
    int   k;
    int   pr;
    exp_t e;
    k     = edge_n + 1;
    rst   = r;
    start = s;
    a     = x;
    b     = y;
    if (r) begin
      q.delete();
      last_rst = k;
      abort_e  = k;
      free_at  = k + 1;
    end else if (s && k >= free_at) begin
      pr   = int'(x) * int'(y);
      e.de = k + 12;
      e.p  = 8'(pr);
      e.d2 = 4'(pr / 100);
      e.d1 = 4'((pr / 10) % 10);
      e.d0 = 4'(pr % 10);
      q.push_back(e);
      last_k  = k;
      abort_e = 1 << 30;
      free_at = k + 13;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
  endtask

  task automatic op(input logic [3:0] x, input logic [3:0] y);
    step(1'b0, 1'b1, x, y);
    idle(13);
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_n, act, req);
    end
  endtask

  // monitor: samples 1 time unit after each rising edge
  initial begin
    logic exp_busy;
    logic exp_done;
    int   e;
    forever begin
      @(posedge clk);
      #1;
      e = edge_n;
      exp_busy = (e >= last_k) && (e < last_k + 12) && (e < abort_e);
      chk8("busy", {7'd0, busy}, {7'd0, exp_busy});
      exp_done = (q.size() > 0) && (q[0].de == e);
      chk8("done", {7'd0, done}, {7'd0, exp_done});
      if (exp_done) begin
        h_p  = q[0].p;
        h_d2 = q[0].d2;
        h_d1 = q[0].d1;
        h_d0 = q[0].d0;
        void'(q.pop_front());
      end else if (e == last_rst) begin
        h_p  = 8'd0;
        h_d2 = 4'd0;
        h_d1 = 4'd0;
        h_d0 = 4'd0;
      end
      chk8("product", product, h_p);
      chk8("bcd2", {4'd0, bcd2}, {4'd0, h_d2});
      chk8("bcd1", {4'd0, bcd1}, {4'd0, h_d1});
      chk8("bcd0", {4'd0, bcd0}, {4'd0, h_d0});
      if (q.size() > 0 && q[0].de < e) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_done: expected at edge %0d, now %0d", q[0].de, e);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    idle(2);

    op(4'd2, 4'd2);
    op(4'd7, 4'd2);
    op(4'd5, 4'd2);
    op(4'd3, 4'd3);
    op(4'd15, 4'd15);
    op(4'd0, 4'd9);

    // start during busy is ignored
    step(1'b0, 1'b1, 4'd4, 4'd4);
    idle(2);
    step(1'b0, 1'b1, 4'd9, 4'd9);
    idle(13);

    // reset aborts an operation in progress
    step(1'b0, 1'b1, 4'd6, 4'd7);
    idle(5);
    step(1'b1, 1'b0, 4'd6, 4'd7);
    idle(2);
    op(4'd6, 4'd7);

    // start held high: back-to-back every 13 cycles
    for (int i = 0; i < 39; i++)
      step(1'b0, 1'b1, 4'd3, 4'd5);
    idle(14);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(79) == 0),
           ($urandom_range(3) == 0),
           4'($urandom_range(15)),
           4'($urandom_range(15)));
    end
    idle(20);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
